// File: rtl/pu_or1k_dpram_fifo.sv
// First-word-fall-through FIFO that acts as the port controller for a bypassing simple dual-port RAM.
// Optional almost_full comparator is enabled by defining PU_OR1K_FIFO_ALMOST_FULL_EN.

module pu_or1k_simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ENABLE_BYPASS = 1
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [(1 << ADDR_WIDTH)-1:0];
  logic [DATA_WIDTH-1:0] rdata;

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= din;
    if (re)
      rdata <= mem[raddr];
  end

  // A same-cycle read of the address being written returns the new data, not the stale cell.
  if (ENABLE_BYPASS != 0) begin : g_bypass
    logic [DATA_WIDTH-1:0] din_r;
    logic                  bypass;

    always_ff @(posedge clk) begin
      if (re) begin
        din_r  <= din;
        bypass <= we && (waddr == raddr);
      end
    end

    assign dout = bypass ? din_r : rdata;
  end else begin : g_no_bypass
    assign dout = rdata;
  end

endmodule

module pu_or1k_dpram_fifo #(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ALMOST_FULL = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic [DEPTH_WIDTH:0]   count,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full
);

  localparam logic [DEPTH_WIDTH:0] DEPTH = (DEPTH_WIDTH+1)'(1 << DEPTH_WIDTH);

  if (ALMOST_FULL < 1 || ALMOST_FULL > (1 << DEPTH_WIDTH)) begin : g_bad_almost_full
    $error("pu_or1k_dpram_fifo: ALMOST_FULL outside 1..2**DEPTH_WIDTH");
  end

  logic [DEPTH_WIDTH-1:0] wptr;
  logic [DEPTH_WIDTH-1:0] rptr;
  logic [DEPTH_WIDTH:0]   count_next;
  logic                   wr_fire;
  logic                   rd_fire;
  logic                   re;
  logic                   stored_nz;

  assign full     = (count == DEPTH);
  assign empty    = (count == '0);
  assign wr_ready = !full;

  assign wr_fire = wr_valid && !full && !flush;
  assign rd_fire = rd_valid && rd_ready;

  // Entries still sitting in the RAM are everything counted except the word already on rd_data.
  assign stored_nz = (count > {{DEPTH_WIDTH{1'b0}}, rd_valid});
  assign re        = !flush && (!rd_valid || rd_ready) && (stored_nz || wr_fire);

  always_comb begin
    count_next = count;
    if (flush)
      count_next = '0;
    else begin
      case ({wr_fire, rd_fire})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      count <= count_next;
      if (flush) begin
        wptr     <= '0;
        rptr     <= '0;
        rd_valid <= 1'b0;
      end else begin
        if (wr_fire)
          wptr <= wptr + 1'b1;
        if (re)
          rptr <= rptr + 1'b1;
        if (re)
          rd_valid <= 1'b1;
        else if (rd_ready)
          rd_valid <= 1'b0;
      end
    end
  end

`ifdef PU_OR1K_FIFO_ALMOST_FULL_EN
  localparam logic [DEPTH_WIDTH:0] AF_LEVEL = (DEPTH_WIDTH+1)'(ALMOST_FULL);

  logic almost_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      almost_full_q <= 1'b0;
    else
      almost_full_q <= (count_next >= AF_LEVEL);
  end

  assign almost_full = almost_full_q;
`else
  assign almost_full = 1'b0;
`endif

  pu_or1k_simple_dpram_sclk #(
    .ADDR_WIDTH    (DEPTH_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .ENABLE_BYPASS (1)
  ) u_ram (
    .clk   (clk),
    .raddr (rptr),
    .re    (re),
    .waddr (wptr),
    .we    (wr_fire),
    .din   (wr_data),
    .dout  (rd_data)
  );

endmodule

// File: tb/tb_pu_or1k_dpram_fifo.sv
// Scoreboard bench for pu_or1k_dpram_fifo: a driver pushes expected words, a negedge monitor pops and compares.
// almost_full expectations follow PU_OR1K_FIFO_ALMOST_FULL_EN.

module tb_pu_or1k_dpram_fifo;

  localparam int DW    = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 1 << DW;
  localparam int AF    = 12;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic [DW:0]      count;
  logic             full;
  logic             empty;
  logic             almost_full;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb_q [$];
  int               model_count = 0;

  pu_or1k_dpram_fifo #(
    .DEPTH_WIDTH (DW),
    .DATA_WIDTH  (WIDTH),
    .ALMOST_FULL (AF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic expAlmostFull(input int c);
`ifdef PU_OR1K_FIFO_ALMOST_FULL_EN
    return (c >= AF);
`else
    return (c < 0);
`endif
  endfunction

  // One clock of stimulus; the expected word is queued only when the model says the write is accepted.
  task automatic applyStimulus(input logic wv, input logic [WIDTH-1:0] wd, input logic rr, input logic fl);
    logic accept;
    logic pop;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    accept   = wv && (model_count < DEPTH) && !fl;
    pop      = (model_count > 0) && rr;
    @(posedge clk);
    if (fl) begin
      sb_q.delete();
      model_count = 0;
    end else begin
      if (accept)
        sb_q.push_back(wd);
      model_count = model_count + int'(accept) - int'(pop);
    end
    #1;
  endtask

  task automatic idleCycles(input int n, input logic rr);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, '0, rr, 1'b0);
  endtask

  // Monitor: status against the model every cycle, data against the scoreboard head whenever presented.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("count", 64'(count), 64'(model_count));
      checkOutput("rd_valid", 64'(rd_valid), 64'(model_count > 0));
      checkOutput("wr_ready", 64'(wr_ready), 64'(model_count < DEPTH));
      checkOutput("almost_full", 64'(almost_full), 64'(expAlmostFull(model_count)));
      if (rd_valid) begin
        if (sb_q.size() == 0) begin
          checkOutput("rd_valid_with_empty_scoreboard", 64'(rd_valid), 64'(0));
        end else begin
          checkOutput("rd_data", 64'(rd_data), 64'(sb_q[0]));
          if (rd_ready)
            void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_count", 64'(count), 64'(0));
    checkOutput("reset_empty", 64'(empty), 64'(1));
    checkOutput("reset_full", 64'(full), 64'(0));
    checkOutput("reset_wr_ready", 64'(wr_ready), 64'(1));
    checkOutput("reset_rd_valid", 64'(rd_valid), 64'(0));
    checkOutput("reset_almost_full", 64'(almost_full), 64'(0));
    rst_n = 1'b1;
    idleCycles(2, 1'b0);

    // Single write with a stalled consumer
    applyStimulus(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    checkOutput("first_rd_valid", 64'(rd_valid), 64'(1));
    checkOutput("first_rd_data", 64'(rd_data), 64'(32'hA5A5_0001));
    checkOutput("first_count", 64'(count), 64'(1));
    idleCycles(5, 1'b0);
    checkOutput("stalled_rd_data", 64'(rd_data), 64'(32'hA5A5_0001));
    idleCycles(1, 1'b1);
    checkOutput("after_pop_empty", 64'(empty), 64'(1));

    // Fill to full, overflow attempt, then drain in order
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, WIDTH'(i), 1'b0, 1'b0);
    checkOutput("fill_full", 64'(full), 64'(1));
    checkOutput("fill_wr_ready", 64'(wr_ready), 64'(0));
    checkOutput("fill_count", 64'(count), 64'(16));
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    checkOutput("overflow_count", 64'(count), 64'(16));
    idleCycles(DEPTH, 1'b1);
    checkOutput("drain_empty", 64'(empty), 64'(1));
    checkOutput("drain_rd_valid", 64'(rd_valid), 64'(0));

    // Streaming: one write and one read per cycle, pointers wrap twice
    for (int i = 0; i < 40; i++)
      applyStimulus(1'b1, WIDTH'(i), 1'b1, 1'b0);
    checkOutput("stream_count", 64'(count), 64'(1));
    idleCycles(1, 1'b1);
    checkOutput("stream_empty", 64'(empty), 64'(1));

    // Full FIFO with simultaneous write and pop: pop only, write lands next cycle
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, WIDTH'(32'h100 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0);
    checkOutput("full_pop_count", 64'(count), 64'(15));
    applyStimulus(1'b1, 32'h201, 1'b0, 1'b0);
    checkOutput("full_retry_count", 64'(count), 64'(16));
    idleCycles(DEPTH, 1'b1);
    checkOutput("full_drain_empty", 64'(empty), 64'(1));

    // Flush with a concurrent write, then reuse
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b1, WIDTH'(32'h300 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h377, 1'b0, 1'b1);
    checkOutput("flush_count", 64'(count), 64'(0));
    checkOutput("flush_rd_valid", 64'(rd_valid), 64'(0));
    checkOutput("flush_empty", 64'(empty), 64'(1));
    checkOutput("flush_wr_ready", 64'(wr_ready), 64'(1));
    applyStimulus(1'b1, 32'h1234, 1'b0, 1'b0);
    checkOutput("post_flush_rd_data", 64'(rd_data), 64'(32'h1234));
    idleCycles(1, 1'b1);

    // almost_full threshold crossing
    for (int i = 0; i < AF - 1; i++)
      applyStimulus(1'b1, WIDTH'(32'h400 + i), 1'b0, 1'b0);
    checkOutput("af_below", 64'(almost_full), 64'(0));
    applyStimulus(1'b1, WIDTH'(32'h400 + AF - 1), 1'b0, 1'b0);
`ifdef PU_OR1K_FIFO_ALMOST_FULL_EN
    checkOutput("af_at_threshold", 64'(almost_full), 64'(1));
`else
    checkOutput("af_at_threshold", 64'(almost_full), 64'(0));
`endif
    idleCycles(1, 1'b1);
    checkOutput("af_after_pop", 64'(almost_full), 64'(0));
    idleCycles(AF, 1'b1);
    checkOutput("final_empty", 64'(empty), 64'(1));

    idleCycles(2, 1'b0);
    checkOutput("scoreboard_leftover", 64'(sb_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_or1k_dpram_fifo.md
# pu_or1k_dpram_fifo

Synchronous first-word-fall-through FIFO that drives the read and write ports of `pu_or1k_simple_dpram_sclk` (instantiated with `ENABLE_BYPASS=1`), acting as the port controller for that RAM. It generates `raddr`, `re`, `waddr`, `we` and `din` from valid/ready handshakes, and presents RAM `dout` directly as the read data. It buffers instruction-fetch and store traffic between the core pipeline and the Wishbone interface.

## Interface
- `DEPTH_WIDTH`, 4: log2 of storage depth; RAM `ADDR_WIDTH` = `DEPTH_WIDTH`.
- `DATA_WIDTH`, 32: entry width.
- `ALMOST_FULL`, 12: `count` threshold for `almost_full`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous clear; wins over all other inputs.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  FIFO can accept; equals `!full`.
- `wr_data`  in  DATA_WIDTH  write payload.
- `rd_valid`  out  1  `rd_data` holds the oldest entry.
- `rd_ready`  in  1  consumer accepts `rd_data`.
- `rd_data`  out  DATA_WIDTH  RAM `dout`.
- `count`  out  DEPTH_WIDTH+1  entries held, including the one on `rd_data`.
- `full`  out  1  `count == 2**DEPTH_WIDTH`.
- `empty`  out  1  `count == 0`.
- `almost_full`  out  1  see Configuration.

## Operation
- Write fire: `wr_valid && wr_ready`. It drives `we=1`, `waddr=wptr`, `din=wr_data`, then increments `wptr`.
- Prefetch condition: `re = (!rd_valid || rd_ready) && (stored>0 || write fire)`. Here `stored` is the number of entries held in RAM, not yet read. `raddr=rptr`, and `rptr` increments on `re`.
- Read from an empty RAM during a same-cycle write: `raddr == waddr` and the RAM bypass returns `wr_data`.
- `rd_valid` next = `re ? 1 : (rd_ready ? 0 : rd_valid)`.
- With `re=0`, RAM `dout` holds. `rd_data` is therefore stable while `rd_valid && !rd_ready`.
- `count` next = `count + write fire - (rd_valid && rd_ready)`. Simultaneous write and read keeps `count` unchanged.
- Pointers are `DEPTH_WIDTH` bits wide and wrap modulo `2**DEPTH_WIDTH` without special handling. Full/empty come from `count` only.
- `wr_ready` depends only on `full`, never on `rd_ready`. When full, a same-cycle pop does not admit a write.
- `flush` (synchronous) sets `wptr`, `rptr`, `count` to 0 and `rd_valid` to 0, and forces `we=re=0`. A concurrent write is dropped.
- Reset values: `wptr=rptr=0`, `count=0`, `rd_valid=0`, `wr_ready=1`, `full=0`, `empty=1`, `almost_full=0`. `rd_data` is don't-care while `rd_valid=0`.
- Asserting reset mid-operation discards all contents. RAM contents are not cleared.

## Timing
- Write to empty FIFO: data accepted at edge E gives `rd_valid=1` with that data after E (1 cycle; bypass path).
- Write to a non-empty FIFO: data becomes visible after all older entries have popped, one entry per cycle at full throughput.
- Sustained throughput: 1 write and 1 read per cycle with no bubbles.
- `full`, `empty`, `count`, `almost_full` are registered or derived from registered `count`. Each updates in the cycle after the causing edge.
- `flush` takes effect at the next edge. `wr_ready=1` and `rd_valid=0` in the following cycle.

## Configuration
- `PU_OR1K_FIFO_ALMOST_FULL_EN` defined: `almost_full = (count >= ALMOST_FULL)`, registered with `count`.
- Macro undefined: `almost_full` is tied to 0 and the comparator is not built. The port stays present in both cases.

## Test plan
- Reset, then one write of `0xA5A5_0001` with `rd_ready=0`: `rd_valid=1` one cycle later and `rd_data=0xA5A5_0001`, `count=1`. Data holds for 5 stalled cycles.
- Fill 16 entries (`DEPTH_WIDTH=4`) with values `0..15`, `rd_ready=0`: `full=1`, `wr_ready=0`, and a 17th write is ignored. Then drain: reads return `0..15` in order, ending with `empty=1`.
- Continuous write and read with `rd_ready=1` for 40 cycles, data `= cycle index`: every value is received exactly once in order, `count` stays at 1, and pointers wrap twice.
- Full FIFO with `wr_valid=1` and `rd_ready=1` in the same cycle: one pop occurs, the write is not accepted, `count=15`. The write is accepted on the next cycle.
- `flush` with 7 entries and a concurrent write: the next cycle shows `count=0`, `rd_valid=0`, `empty=1`. A subsequent write of `0x1234` reads back `0x1234`.
- With the macro defined and `ALMOST_FULL=12`, write 12 entries: `almost_full` rises after the 12th write and falls after the first pop. With the macro undefined, `almost_full` stays 0 throughout.
